dsp_mem_stage: RTL and testbench



---
 rtl/dsp_mem_stage.sv | 204 ++++++++++++++++++++
 tb/tb_dsp_mem_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mem_stage.sv
// dsp_mem_stage: memory / write-back stage of the DSP datapath.
//
// Accepts one decoded operation per valid/ready handshake and turns it into
// banked SRAM requests and a single-cycle register-file write-back pulse.
// Loads stall upstream until the SRAM read data has come back. Every request
// and write-back output is a register.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_in_valid          operation present from decode
//   o_in_ready          stage can accept an operation this cycle
//   i_mem_mode          0 NONE, 1 LD, 2 ST, 3 LD_IMM, 4..7 illegal
//   i_data_s1           LD/ST address (bank in the top bits) or LD_IMM literal
//   i_data_s2           store data
//   i_alu_result        write-back value for NONE
//   i_write_back_en     NONE writes i_alu_result back when 1
//   i_dest_idx          destination register
//   o_sram_addr         address shared by all banks
//   o_sram_wdata        store data
//   o_sram_we           one-hot bank write strobe
//   o_sram_re           one-hot bank read strobe
//   i_sram_rdata        bank b read data at [b*WORD_LEN +: WORD_LEN]
//   o_wb_valid          register-file write strobe, one cycle
//   o_wb_data           write-back value
//   o_wb_idx            write-back register
//   o_err_illegal       sticky flag: an illegal mem_mode was accepted
module dsp_mem_stage #(
    parameter int WORD_LEN    = 16,
    parameter int ADDR_LEN    = 8,
    parameter int NUM_BANKS   = 2,
    parameter int RD_LAT      = 1,
    parameter int REG_IDX_LEN = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [2:0]                    i_mem_mode,
    input  logic [WORD_LEN-1:0]           i_data_s1,
    input  logic [WORD_LEN-1:0]           i_data_s2,
    input  logic [WORD_LEN-1:0]           i_alu_result,
    input  logic                          i_write_back_en,
    input  logic [REG_IDX_LEN-1:0]        i_dest_idx,
    output logic [ADDR_LEN-1:0]           o_sram_addr,
    output logic [WORD_LEN-1:0]           o_sram_wdata,
    output logic [NUM_BANKS-1:0]          o_sram_we,
    output logic [NUM_BANKS-1:0]          o_sram_re,
    input  logic [NUM_BANKS*WORD_LEN-1:0] i_sram_rdata,
    output logic                          o_wb_valid,
    output logic [WORD_LEN-1:0]           o_wb_data,
    output logic [REG_IDX_LEN-1:0]        o_wb_idx,
    output logic                          o_err_illegal
);

    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    // Bank index vectors keep at least one bit so a single-bank build stays legal.
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int CNT_W     = 2;

    localparam logic [2:0] MODE_NONE   = 3'd0;
    localparam logic [2:0] MODE_LD     = 3'd1;
    localparam logic [2:0] MODE_ST     = 3'd2;
    localparam logic [2:0] MODE_LD_IMM = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_ISSUE = 2'd1,
        S_RD_WAIT  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [BANK_W-1:0]        r_bank;
    logic [REG_IDX_LEN-1:0]   r_ld_idx;
    logic [ADDR_LEN-1:0]      r_sram_addr;
    logic [WORD_LEN-1:0]      r_sram_wdata;
    logic [NUM_BANKS-1:0]     r_sram_we;
    logic [NUM_BANKS-1:0]     r_sram_re;
    logic                     r_wb_valid;
    logic [WORD_LEN-1:0]      r_wb_data;
    logic [REG_IDX_LEN-1:0]   r_wb_idx;
    logic                     r_err_illegal;

    logic                     w_accept;
    logic [BANK_W-1:0]        w_bank;
    logic [NUM_BANKS-1:0]     w_bank_oh;
    logic [WORD_LEN-1:0]      w_rdata_sel;

    // Bank select comes from the top bits of the address operand.
    generate
        if (BANK_BITS > 0) begin : g_bank_sel
            assign w_bank = i_data_s1[WORD_LEN-1 -: BANK_W];
        end else begin : g_bank_single
            assign w_bank = 1'b0;
        end
    endgenerate

    // Ready is dropped while reset is held so nothing is accepted during reset.
    assign o_in_ready = (r_state == S_IDLE) & ~i_rst;
    assign w_accept   = i_in_valid & o_in_ready;

    // One-hot decode of the bank selected by the incoming operation.
    always_comb begin
        w_bank_oh = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bank_oh[b] = (w_bank == BANK_W'(b));
        end
    end

    // Read-data mux driven by the bank latched when the load was issued.
    always_comb begin
        w_rdata_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_rdata_sel = (r_bank == BANK_W'(b)) ? i_sram_rdata[b*WORD_LEN +: WORD_LEN]
                                                 : w_rdata_sel;
        end
    end

    // Stage FSM together with all registered SRAM and write-back outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bank        <= '0;
            r_ld_idx      <= '0;
            r_sram_addr   <= '0;
            r_sram_wdata  <= '0;
            r_sram_we     <= '0;
            r_sram_re     <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_data     <= '0;
            r_wb_idx      <= '0;
            r_err_illegal <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below.
            r_sram_we  <= '0;
            r_sram_re  <= '0;
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (i_mem_mode)
                            MODE_NONE: begin
                                if (i_write_back_en) begin
                                    r_wb_valid <= 1'b1;
                                    r_wb_data  <= i_alu_result;
                                    r_wb_idx   <= i_dest_idx;
                                end
                            end
                            MODE_LD: begin
                                r_sram_re   <= w_bank_oh;
                                r_sram_addr <= i_data_s1[ADDR_LEN-1:0];
                                r_bank      <= w_bank;
                                r_ld_idx    <= i_dest_idx;
                                r_state     <= S_RD_ISSUE;
                            end
                            MODE_ST: begin
                                r_sram_we    <= w_bank_oh;
                                r_sram_addr  <= i_data_s1[ADDR_LEN-1:0];
                                r_sram_wdata <= i_data_s2;
                            end
                            MODE_LD_IMM: begin
                                r_wb_valid <= 1'b1;
                                r_wb_data  <= i_data_s1;
                                r_wb_idx   <= i_dest_idx;
                            end
                            default: begin
                                r_err_illegal <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RD_ISSUE: begin
                    // The read strobe is live this cycle; count the remaining latency.
                    r_cnt   <= CNT_W'(RD_LAT - 1);
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= w_rdata_sel;
                        r_wb_idx   <= r_ld_idx;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_sram_addr   = r_sram_addr;
    assign o_sram_wdata  = r_sram_wdata;
    assign o_sram_we     = r_sram_we;
    assign o_sram_re     = r_sram_re;
    assign o_wb_valid    = r_wb_valid;
    assign o_wb_data     = r_wb_data;
    assign o_wb_idx      = r_wb_idx;
    assign o_err_illegal = r_err_illegal;

endmodule

// File: tb/tb_dsp_mem_stage.sv
// tb_dsp_mem_stage: directed bench for dsp_mem_stage (2 banks, read latency 3).
// A small banked SRAM model with a 3-stage read pipeline answers the DUT.
// Expected write-backs go into a scoreboard queue when an operation is driven
// and are popped and compared whenever the DUT pulses wb_valid.
module tb_dsp_mem_stage;

    localparam int WL = 16;
    localparam int AL = 8;
    localparam int NB = 2;
    localparam int RL = 3;
    localparam int IL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        mem_mode;
    logic [WL-1:0]     data_s1;
    logic [WL-1:0]     data_s2;
    logic [WL-1:0]     alu_result;
    logic              write_back_en;
    logic [IL-1:0]     dest_idx;
    logic [AL-1:0]     sram_addr;
    logic [WL-1:0]     sram_wdata;
    logic [NB-1:0]     sram_we;
    logic [NB-1:0]     sram_re;
    logic [NB*WL-1:0]  sram_rdata;
    logic              wb_valid;
    logic [WL-1:0]     wb_data;
    logic [IL-1:0]     wb_idx;
    logic              err_illegal;

    int n_vec = 0;
    int n_err = 0;

    logic [WL+IL-1:0]  sb_q[$];
    logic [WL+IL-1:0]  sb_item;

    // SRAM model state (written only by the model process).
    logic [WL-1:0]     mem_arr [NB][256];
    logic              mem_vld [NB][256];
    logic [WL-1:0]     rd_pipe [NB][RL];

    // Reference contents tracked by the stimulus.
    logic [WL-1:0]     ref_arr [NB][256];
    logic              ref_vld [NB][256];

    always #5 clk = ~clk;

    dsp_mem_stage #(
        .WORD_LEN(WL), .ADDR_LEN(AL), .NUM_BANKS(NB), .RD_LAT(RL), .REG_IDX_LEN(IL)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_mem_mode(mem_mode), .i_data_s1(data_s1), .i_data_s2(data_s2),
        .i_alu_result(alu_result), .i_write_back_en(write_back_en), .i_dest_idx(dest_idx),
        .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .o_sram_we(sram_we),
        .o_sram_re(sram_re), .i_sram_rdata(sram_rdata), .o_wb_valid(wb_valid),
        .o_wb_data(wb_data), .o_wb_idx(wb_idx), .o_err_illegal(err_illegal)
    );

    function automatic logic [WL-1:0] init_pat(input int b, input int a);
        logic [7:0] bb;
        logic [7:0] aa;
        bb = 8'(b);
        aa = 8'(a);
        if (b == 0 && a == 5) return 16'hA5A5;
        return {4'h5, bb[3:0], aa};
    endfunction

    // Banked SRAM: write on we, read captured on re and delayed RL-1 more cycles.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (rst) begin
                for (int a = 0; a < 256; a++) mem_vld[b][a] <= 1'b0;
            end else if (sram_we[b]) begin
                mem_arr[b][sram_addr] <= sram_wdata;
                mem_vld[b][sram_addr] <= 1'b1;
            end
            if (sram_re[b])
                rd_pipe[b][0] <= mem_vld[b][sram_addr] ? mem_arr[b][sram_addr]
                                                       : init_pat(b, int'(sram_addr));
            else
                rd_pipe[b][0] <= 16'hDEAD;
            for (int k = 1; k < RL; k++) rd_pipe[b][k] <= rd_pipe[b][k-1];
        end
    end

    always_comb begin
        sram_rdata = '0;
        for (int b = 0; b < NB; b++) sram_rdata[b*WL +: WL] = rd_pipe[b][RL-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write-back pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            chk("wb_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                sb_item = sb_q.pop_front();
                chk("sb_wb_data", 32'(wb_data), 32'(sb_item[WL+IL-1:IL]));
                chk("sb_wb_idx",  32'(wb_idx),  32'(sb_item[IL-1:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] mode, input logic [WL-1:0] s1, input logic [WL-1:0] s2,
                         input logic [WL-1:0] alu, input logic wbe, input logic [IL-1:0] idx);
        in_valid      = 1'b1;
        mem_mode      = mode;
        data_s1       = s1;
        data_s2       = s2;
        alu_result    = alu;
        write_back_en = wbe;
        dest_idx      = idx;
    endtask

    function automatic logic [WL-1:0] ref_rd(input int b, input int a);
        return ref_vld[b][a] ? ref_arr[b][a] : init_pat(b, a);
    endfunction

    initial begin
        logic [2:0]    alt_mode [4];
        logic [WL-1:0] alt_s1   [4];
        logic [WL-1:0] alt_s2   [4];

        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 256; a++) ref_vld[b][a] = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0; mem_mode = 3'd0; data_s1 = '0; data_s2 = '0;
        alu_result = '0; write_back_en = 1'b0; dest_idx = '0;

        // Reset state
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(sram_we), 32'd0);
        chk("rst_re", 32'(sram_re), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_wdata", 32'(sram_wdata), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_wb_idx", 32'(wb_idx), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // NONE with write-back
        drive(3'd0, 16'h0000, 16'h0000, 16'h1234, 1'b1, 4'd3);
        sb_q.push_back({16'h1234, 4'd3});
        tick(); in_valid = 1'b0;
        chk("none_wb_valid", 32'(wb_valid), 32'd1);
        chk("none_wb_data", 32'(wb_data), 32'h1234);
        chk("none_wb_idx", 32'(wb_idx), 32'd3);
        tick();
        chk("none_wb_pulse", 32'(wb_valid), 32'd0);

        // NONE without write-back
        drive(3'd0, 16'h0000, 16'h0000, 16'h5555, 1'b0, 4'd6);
        tick(); in_valid = 1'b0;
        chk("nowb_valid", 32'(wb_valid), 32'd0);
        chk("nowb_hold", 32'(wb_data), 32'h1234);

        // ST to bank 1
        drive(3'd2, 16'h8005, 16'hBEEF, 16'h0000, 1'b0, 4'd0);
        ref_arr[1][5] = 16'hBEEF; ref_vld[1][5] = 1'b1;
        tick(); in_valid = 1'b0;
        chk("st_we", 32'(sram_we), 32'b10);
        chk("st_re", 32'(sram_re), 32'd0);
        chk("st_addr", 32'(sram_addr), 32'h05);
        chk("st_wdata", 32'(sram_wdata), 32'hBEEF);
        chk("st_no_wb", 32'(wb_valid), 32'd0);
        tick();
        chk("st_we_pulse", 32'(sram_we), 32'd0);
        chk("st_addr_hold", 32'(sram_addr), 32'h05);

        // LD from bank 0 with 3-cycle latency
        drive(3'd1, 16'h0005, 16'h0000, 16'h0000, 1'b0, 4'd9);
        sb_q.push_back({ref_rd(0, 5), 4'd9});
        tick(); in_valid = 1'b0;
        chk("ld_re", 32'(sram_re), 32'b01);
        chk("ld_addr", 32'(sram_addr), 32'h05);
        chk("ld_ready_t1", 32'(in_ready), 32'd0);
        for (int i = 0; i < RL; i++) begin
            tick();
            chk("ld_re_pulse", 32'(sram_re), 32'd0);
            chk("ld_ready_wait", 32'(in_ready), 32'd0);
            chk("ld_no_early_wb", 32'(wb_valid), 32'd0);
        end
        tick();
        chk("ld_ready_back", 32'(in_ready), 32'd1);
        chk("ld_wb_valid", 32'(wb_valid), 32'd1);
        chk("ld_wb_data", 32'(wb_data), 32'hA5A5);

        // ST then LD of the same address, with a ST held across the stall
        drive(3'd2, 16'h8007, 16'h1357, 16'h0000, 1'b0, 4'd0);
        ref_arr[1][7] = 16'h1357; ref_vld[1][7] = 1'b1;
        tick();
        drive(3'd1, 16'h8007, 16'h0000, 16'h0000, 1'b0, 4'd10);
        sb_q.push_back({ref_rd(1, 7), 4'd10});
        chk("stld_we", 32'(sram_we), 32'b10);
        tick();
        drive(3'd2, 16'h0020, 16'h7777, 16'h0000, 1'b0, 4'd0);
        ref_arr[0][32] = 16'h7777; ref_vld[0][32] = 1'b1;
        chk("stld_re", 32'(sram_re), 32'b10);
        for (int i = 0; i < RL; i++) begin
            tick();
            chk("stall_ignored_we", 32'(sram_we), 32'd0);
        end
        tick();
        chk("stld_wb_data", 32'(wb_data), 32'h1357);
        chk("held_ready", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0;
        chk("held_st_we", 32'(sram_we), 32'b01);
        chk("held_st_wdata", 32'(sram_wdata), 32'h7777);

        // LD_IMM alternating with ST, accepted every cycle
        alt_mode[0] = 3'd3; alt_s1[0] = 16'h7F00; alt_s2[0] = 16'h0000;
        alt_mode[1] = 3'd2; alt_s1[1] = 16'h0010; alt_s2[1] = 16'h0BAD;
        alt_mode[2] = 3'd3; alt_s1[2] = 16'h7F00; alt_s2[2] = 16'h0000;
        alt_mode[3] = 3'd2; alt_s1[3] = 16'h8011; alt_s2[3] = 16'hCAFE;
        for (int i = 0; i < 4; i++) begin
            drive(alt_mode[i], alt_s1[i], alt_s2[i], 16'h0000, 1'b0, 4'(i + 1));
            if (alt_mode[i] == 3'd3) sb_q.push_back({alt_s1[i], 4'(i + 1)});
            chk("alt_ready", 32'(in_ready), 32'd1);
            tick();
            if (alt_mode[i] == 3'd3) begin
                chk("alt_imm_wb", 32'(wb_valid), 32'd1);
                chk("alt_imm_data", 32'(wb_data), 32'h7F00);
                chk("alt_imm_no_we", 32'(sram_we), 32'd0);
            end else begin
                chk("alt_st_we", 32'(sram_we), (alt_s1[i][15]) ? 32'b10 : 32'b01);
                chk("alt_st_wdata", 32'(sram_wdata), 32'(alt_s2[i]));
                chk("alt_st_no_wb", 32'(wb_valid), 32'd0);
            end
        end
        in_valid = 1'b0;

        // Illegal mode
        drive(3'd5, 16'h8005, 16'h1111, 16'h2222, 1'b1, 4'd7);
        tick(); in_valid = 1'b0;
        chk("ill_err", 32'(err_illegal), 32'd1);
        chk("ill_we", 32'(sram_we), 32'd0);
        chk("ill_re", 32'(sram_re), 32'd0);
        chk("ill_wb", 32'(wb_valid), 32'd0);
        tick(); tick(); tick();
        chk("ill_sticky", 32'(err_illegal), 32'd1);
        chk("ill_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a load
        drive(3'd1, 16'h0005, 16'h0000, 16'h0000, 1'b0, 4'd12);
        tick(); in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_wb", 32'(wb_valid), 32'd0);
        chk("mid_rst_err", 32'(err_illegal), 32'd0);
        chk("mid_rst_addr", 32'(sram_addr), 32'd0);
        chk("mid_rst_wb_data", 32'(wb_data), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready_after", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) tick();

        // Stage still operates after the abandoned load
        drive(3'd0, 16'h0000, 16'h0000, 16'h0F0F, 1'b1, 4'd15);
        sb_q.push_back({16'h0F0F, 4'd15});
        tick(); in_valid = 1'b0;
        chk("post_rst_wb", 32'(wb_valid), 32'd1);
        tick(); tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
